// File: rtl/onchip_mem_stream_pkg.sv
// -----------------------------------------------------------------------------
// onchip_mem_stream_pkg
//   Shared definitions for the on-chip RAM stream reader:
//   - default widths for the RAM word address, data word and length command
//   - FSM state encoding (IDLE / ISSUE / DRAIN)
//   - beat_t: one buffered stream word with its SOP/EOP markers
//   beat_t is sized by DEF_DATA_W, so a reader instance must use
//   DATA_W == DEF_DATA_W.
// -----------------------------------------------------------------------------
package onchip_mem_stream_pkg;

   localparam int DEF_ADDR_W     = 15;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_LEN_W      = 16;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_e;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] data;
      logic                  sop;
      logic                  eop;
   } beat_t;

endpackage

// File: rtl/stream_reader_fifo.sv
// -----------------------------------------------------------------------------
// stream_reader_fifo
//   Synchronous FIFO of beat_t entries used as the reader's output buffer.
//   DEPTH must be a power of two and >= 2, so pointers wrap naturally.
//   Ports:
//     clk, reset_n  clock, asynchronous active-low reset
//     push          write push_data this cycle (ignored when full)
//     push_data     beat to store
//     pop           drop the head entry this cycle (ignored when empty)
//     pop_data      head entry (show-ahead)
//     count         number of stored entries, 0..DEPTH
//     empty, full   status flags derived from count
//   A simultaneous push and pop leaves count unchanged.
// -----------------------------------------------------------------------------
module stream_reader_fifo
   import onchip_mem_stream_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  beat_t                  push_data,
   input  logic                   pop,
   output beat_t                  pop_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);

   localparam int PTR_W = $clog2(DEPTH);

   beat_t            mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: the storage array has no reset; only the pointers and count
   // define which entries are meaningful, so clearing the data is wasted logic.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign pop_data = mem[rd_ptr];
   assign empty    = (count == '0);
   assign full     = (count == (PTR_W + 1)'(DEPTH));

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// -----------------------------------------------------------------------------
// onchip_mem_stream_reader
//   Avalon-style read master for the single-port on-chip RAM (1-cycle read
//   latency). A start command reads cmd_len contiguous words from cmd_base
//   (address wraps modulo 2^ADDR_W) and emits them as a valid/ready stream
//   with SOP/EOP markers. Reads are issued only while the output FIFO has a
//   free slot for every word in flight, so backpressure never reaches the RAM.
//
//   Optional feature macro: ONCHIP_MEM_STREAM_READER_CHECKSUM_EN
//     adds output `checksum`: modulo-2^DATA_W sum of accepted beats, cleared
//     on an accepted start, holding its final value after done.
//
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     cmd_start           start pulse (ignored while busy)
//     cmd_base, cmd_len   first word address / word count, sampled on start
//     busy                accepted start until the last beat is accepted
//     done                one-cycle completion pulse
//     mem_*               RAM port (write tied off, clken tied on)
//     out_data/valid/ready/sop/eop   output stream
//     checksum            (macro only) running sum of accepted beats
// -----------------------------------------------------------------------------
module onchip_mem_stream_reader
   import onchip_mem_stream_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int LEN_W      = DEF_LEN_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_start,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [3:0]        mem_byteenable,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sop,
   output logic              out_eop
`ifdef ONCHIP_MEM_STREAM_READER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_e            state_q;
   state_e            state_d;
   logic [ADDR_W-1:0] cur_addr;
   logic [LEN_W-1:0]  issue_rem;
   logic [LEN_W-1:0]  len_q;
   logic              inflight;
   logic              inflight_sop;
   logic              inflight_eop;
   logic              done_q;
   logic              done_d;
   logic              start_acc;
   logic              issue;
   logic              credit_ok;
   logic              pop;

   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic              fifo_full;
   beat_t             push_beat;
   beat_t             head_beat;

   // A read may issue only if the word it returns (plus the one already in
   // flight) is guaranteed a FIFO slot, ignoring any pop this cycle.
   assign credit_ok = !fifo_full &&
                      ((fifo_count + CNT_W'(inflight)) < CNT_W'(FIFO_DEPTH));

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement leaves a value unassigned and infers a latch.
   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      issue     = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_start) begin
               start_acc = 1'b1;
               if (cmd_len != '0) state_d = ISSUE;
               else               done_d  = 1'b1;  // empty transfer: done only
            end
         end
         ISSUE: begin
            if (credit_ok) begin
               issue = 1'b1;
               if (issue_rem == LEN_W'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head_beat.eop) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cur_addr     <= '0;
         issue_rem    <= '0;
         len_q        <= '0;
         inflight     <= 1'b0;
         inflight_sop <= 1'b0;
         inflight_eop <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         done_q       <= done_d;
         // Markers travel with the read so the FIFO entry is self-describing.
         inflight     <= issue;
         inflight_sop <= issue && (issue_rem == len_q);
         inflight_eop <= issue && (issue_rem == LEN_W'(1));
         if (start_acc) begin
            cur_addr  <= cmd_base;
            issue_rem <= cmd_len;
            len_q     <= cmd_len;
         end else if (issue) begin
            cur_addr  <= cur_addr + 1'b1;  // wraps modulo 2^ADDR_W
            issue_rem <= issue_rem - 1'b1;
         end
      end
   end

   // RAM data is valid the cycle after the issue; capture it straight into
   // the FIFO.
   always_comb begin
      push_beat      = '0;
      push_beat.data = mem_readdata;
      push_beat.sop  = inflight_sop;
      push_beat.eop  = inflight_eop;
   end

   stream_reader_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (inflight),
      .push_data (push_beat),
      .pop       (pop),
      .pop_data  (head_beat),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign pop       = out_valid && out_ready;
   assign out_valid = !fifo_empty;
   // Head fields are gated by valid so outputs read zero while empty.
   assign out_data  = out_valid ? head_beat.data : '0;
   assign out_sop   = out_valid && head_beat.sop;
   assign out_eop   = out_valid && head_beat.eop;

   assign busy           = (state_q != IDLE);
   assign done           = done_q;
   assign mem_address    = cur_addr;
   assign mem_chipselect = issue;
   assign mem_write      = 1'b0;
   assign mem_byteenable = 4'hF;
   assign mem_clken      = 1'b1;

`ifdef ONCHIP_MEM_STREAM_READER_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         checksum <= '0;
      end else if (start_acc) begin
         checksum <= '0;
      end else if (pop) begin
         checksum <= checksum + out_data;
      end
   end
`endif

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_onchip_mem_stream_reader
//   Scoreboard bench: each command pushes its expected addresses and beats,
//   computed from a plain RAM array, into queues; a negedge monitor pops and
//   compares whenever the DUT issues a read or transfers a beat.
//   Define ONCHIP_MEM_STREAM_READER_CHECKSUM_EN to also check `checksum`.
// -----------------------------------------------------------------------------
module tb_onchip_mem_stream_reader;

   localparam int ADDR_W    = 15;
   localparam int DATA_W    = 32;
   localparam int LEN_W     = 16;
   localparam int DEPTH     = 4;
   localparam int RAM_WORDS = 32768;

   logic              clk;
   logic              reset_n;
   logic              cmd_start;
   logic [ADDR_W-1:0] cmd_base;
   logic [LEN_W-1:0]  cmd_len;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_chipselect;
   logic              mem_write;
   logic [3:0]        mem_byteenable;
   logic              mem_clken;
   logic [DATA_W-1:0] mem_readdata;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_sop;
   logic              out_eop;
`ifdef ONCHIP_MEM_STREAM_READER_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;
`endif

   onchip_mem_stream_reader dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cmd_start      (cmd_start),
      .cmd_base       (cmd_base),
      .cmd_len        (cmd_len),
      .busy           (busy),
      .done           (done),
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_byteenable (mem_byteenable),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_sop        (out_sop),
      .out_eop        (out_eop)
`ifdef ONCHIP_MEM_STREAM_READER_CHECKSUM_EN
      ,
      .checksum       (checksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: one-cycle registered read.
   logic [DATA_W-1:0] ram [RAM_WORDS];
   always @(posedge clk) begin
      if (mem_chipselect) mem_readdata <= ram[mem_address];
   end

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              sop;
      logic              eop;
   } exp_beat_t;

   exp_beat_t         exp_q[$];
   int                addr_q[$];
   int                n_cmp      = 0;
   int                n_err      = 0;
   int                cyc        = 0;
   int                exp_done   = -1;
   logic [DATA_W-1:0] exp_sum    = '0;
   int                outst      = 0;
   int                beats_seen = 0;
   int                sop_cyc    = -1;
   int                eop_cyc    = -1;
   bit                prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data  = '0;
   int                rdy_mode   = 0;
   int                rdy_phase  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // Consumer: 0 = always ready, 1 = one cycle high / three low, 2 = random.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: begin
            out_ready = (rdy_phase == 0);
            rdy_phase = (rdy_phase + 1) % 4;
         end
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor / scoreboard.
   always @(negedge clk) begin
      exp_beat_t e;
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (addr_q.size() == 0) begin
            check("read issued with none expected", 64'(mem_chipselect), 64'(0));
         end else if (mem_chipselect) begin
            check("read address", 64'(mem_address), 64'(addr_q.pop_front()));
            outst++;
         end

         if (prev_stall)
            check("data held while stalled", {31'b0, out_valid, out_data}, {31'b0, 1'b1, prev_data});

         if (exp_q.size() == 0) begin
            check("out_valid with no beat expected", 64'(out_valid), 64'(0));
         end else if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            check("beat data/sop/eop", {30'b0, out_data, out_sop, out_eop}, {30'b0, e.data, e.sop, e.eop});
            outst--;
            beats_seen++;
            if (e.sop) sop_cyc = cyc;
            if (e.eop) begin
               eop_cyc  = cyc;
               exp_done = cyc + 1;
            end
         end

         // Words issued but not yet accepted must always fit the buffer.
         if (mem_chipselect) check("credit bound", 64'(outst <= DEPTH), 64'(1));

         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;

         if (exp_done == cyc) begin
            check("done pulse", 64'(done), 64'(1));
            check("busy low at done", 64'(busy), 64'(0));
`ifdef ONCHIP_MEM_STREAM_READER_CHECKSUM_EN
            check("checksum at done", 64'(checksum), 64'(exp_sum));
`endif
            exp_done = -1;
         end else begin
            check("no stray done", 64'(done), 64'(0));
         end
      end
   end

   task automatic check_reset(input string tag);
      check({tag, " busy"},           64'(busy),           64'(0));
      check({tag, " done"},           64'(done),           64'(0));
      check({tag, " mem_chipselect"}, 64'(mem_chipselect), 64'(0));
      check({tag, " mem_address"},    64'(mem_address),    64'(0));
      check({tag, " out_valid"},      64'(out_valid),      64'(0));
      check({tag, " out_sop"},        64'(out_sop),        64'(0));
      check({tag, " out_eop"},        64'(out_eop),        64'(0));
      check({tag, " out_data"},       64'(out_data),       64'(0));
      check({tag, " mem_write"},      64'(mem_write),      64'(0));
      check({tag, " mem_byteenable"}, 64'(mem_byteenable), 64'(4'hF));
      check({tag, " mem_clken"},      64'(mem_clken),      64'(1));
`ifdef ONCHIP_MEM_STREAM_READER_CHECKSUM_EN
      check({tag, " checksum"},       64'(checksum),       64'(0));
`endif
   endtask

   // Pulse cmd_start for one cycle; when the command should be accepted,
   // queue the addresses and beats the reference model expects.
   task automatic issue_cmd(input int base, input int len, input bit accept, output int start_cyc);
      logic [DATA_W-1:0] s;
      int                a;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      cmd_start = 1'b1;
      cmd_base  = ADDR_W'(base);
      cmd_len   = LEN_W'(len);
      if (accept) begin
         s = '0;
         for (int i = 0; i < len; i++) begin
            a = (base + i) % RAM_WORDS;
            addr_q.push_back(a);
            exp_q.push_back('{data: ram[a], sop: (i == 0), eop: (i == len - 1)});
            s = s + ram[a];
         end
         exp_sum = s;
         if (len == 0) exp_done = cyc + 1;
      end
      @(posedge clk);
      #1;
      cmd_start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || addr_q.size() != 0 || exp_done >= 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      check({tag, " completes within budget"}, 64'(n < budget), 64'(1));
      @(posedge clk);
      #1;
      check({tag, " busy low afterwards"}, 64'(busy), 64'(0));
   endtask

   initial begin
      int sc;
      int b0;
      int n;
      reset_n   = 1'b0;
      cmd_start = 1'b0;
      cmd_base  = '0;
      cmd_len   = '0;
      out_ready = 1'b1;
      for (int i = 0; i < RAM_WORDS; i++) ram[i] = DATA_W'(i);

      repeat (2) @(posedge clk);
      #1;
      check_reset("reset");
      reset_n = 1'b1;

      // Basic 4-word read with a free-running consumer.
      rdy_mode = 0;
      issue_cmd(16'h0010, 4, 1'b1, sc);
      wait_idle("basic", 100);
      check("first beat latency", 64'(sop_cyc), 64'(sc + 3));
      check("beats on consecutive cycles", 64'(eop_cyc - sop_cyc), 64'(3));

      // Address wrap at the top of the RAM.
      issue_cmd(16'h7FFE, 4, 1'b1, sc);
      wait_idle("wrap", 100);

      // Throttled consumer; a start while busy must be ignored.
      rdy_mode  = 1;
      rdy_phase = 0;
      issue_cmd(16'h0100, 20, 1'b1, sc);
      repeat (6) @(posedge clk);
      issue_cmd(16'h0300, 5, 1'b0, sc);
      wait_idle("throttled", 400);

      // Zero-length then single-word transfers.
      rdy_mode = 0;
      issue_cmd(16'h0050, 0, 1'b1, sc);
      wait_idle("len0", 20);
      issue_cmd(16'h0051, 1, 1'b1, sc);
      wait_idle("len1", 20);

      // Reset after three beats of a longer transfer.
      issue_cmd(16'h0200, 20, 1'b1, sc);
      b0 = beats_seen;
      n  = 0;
      while (beats_seen < b0 + 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("three beats before reset", 64'(n < 100), 64'(1));
      #2;
      reset_n = 1'b0;
      #1;
      check_reset("mid-transfer reset");
      exp_q.delete();
      addr_q.delete();
      exp_done = -1;
      outst    = 0;
      repeat (3) @(posedge clk);
      #2;
      check_reset("held reset");
      reset_n = 1'b1;
      issue_cmd(16'h0020, 3, 1'b1, sc);
      wait_idle("after reset", 50);

      // Checksum wrap case: 1 + 0xFFFFFFFF + 5 = 5.
      ram[16'h0400] = 32'h0000_0001;
      ram[16'h0401] = 32'hFFFF_FFFF;
      ram[16'h0402] = 32'h0000_0005;
      issue_cmd(16'h0400, 3, 1'b1, sc);
      wait_idle("checksum words", 50);

      // Random contents, bases, lengths and consumer behaviour.
      for (int i = 0; i < RAM_WORDS; i++) ram[i] = $urandom;
      rdy_mode = 2;
      for (int k = 0; k < 12; k++) begin
         issue_cmd(int'($urandom_range(0, RAM_WORDS - 1)),
                   (k == 5) ? 0 : int'($urandom_range(1, 24)), 1'b1, sc);
         wait_idle("random", 400);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
